// File: rtl/wb_data_ram_pkg.sv
// Shared types for the Wishbone data RAM: FSM encoding, bus widths and
// the address range helper used when WB_DATA_RAM_ERR_EN is defined.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    localparam int WB_AW   = 32;
    localparam int WB_CNTW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_ram_state_t;

    // True when a byte address lies beyond a memory of 2**aw words.
    function automatic logic addr_out_of_range(input logic [WB_AW-1:0] adr, input int aw);
        return (adr >> (aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/wb_data_ram_if.sv
// Wishbone classic bundle between the CPU data-bus master and wb_data_ram.
interface wb_data_ram_if;
    import wb_pkg::*;

    logic                 cyc_i;
    logic                 stb_i;
    logic                 we_i;
    logic [WB_AW-1:0]     adr_i;
    logic [WB_SELW-1:0]   sel_i;
    logic [WB_DW-1:0]     dat_i;
    logic [WB_DW-1:0]     dat_o;
    logic                 ack_o;
    logic                 err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o
    );

endinterface

// File: rtl/wb_data_ram_ram.sv
// Single-port DEPTH x 32 array with per-byte write enables and a read
// register that returns zero on cycles without a read.
module ram_sp_bytewe
    import wb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WB_SELW-1:0] we,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [WB_DW-1:0]   wdata,
    output logic [WB_DW-1:0]   rdata
);

    logic [WB_DW-1:0] mem [DEPTH];
    logic [WB_DW-1:0] rdata_d;
    logic [WB_DW-1:0] rdata_q;

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WB_SELW; k++) begin
            if (we[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Read word selection, zero when no read is issued.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem[addr];
        end else begin
            rdata_d = '0;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone classic data RAM with WAIT_CYCLES wait states and one response per
// strobe. Define WB_DATA_RAM_ERR_EN to answer out-of-range accesses with err_o.
module wb_data_ram
    import wb_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    wb_data_ram_if.slave  bus
);

    localparam int                 AW        = $clog2(DEPTH);
    localparam logic [WB_CNTW-1:0] WAIT_INIT = WB_CNTW'(WAIT_CYCLES);

    wb_ram_state_t       state_d, state_q;
    logic [WB_CNTW-1:0]  cnt_d, cnt_q;
    logic [AW-1:0]       idx_d, idx_q;
    logic                we_d, we_q;
    logic [WB_SELW-1:0]  sel_d, sel_q;
    logic [WB_DW-1:0]    wdat_d, wdat_q;
    logic                ack_d, ack_q;
    logic                err_d, err_q;

    logic [AW-1:0]       cur_idx_s;
    logic                cur_we_s;
    logic [WB_SELW-1:0]  cur_sel_s;
    logic [WB_DW-1:0]    cur_wdat_s;
    logic                go_resp_s;
    logic                blocked_s;
    logic                ram_re_s;
    logic [WB_SELW-1:0]  ram_we_s;
    logic [WB_DW-1:0]    ram_rdata_s;
    logic                unused_adr_s;

`ifdef WB_DATA_RAM_ERR_EN
    logic                oor_d, oor_q;
    logic                cur_oor_s;
`endif

    // Byte offset is meaningless here and upper bits only matter for range checks.
    assign unused_adr_s = ^{bus.adr_i[1:0], bus.adr_i[WB_AW-1:AW+2]};

    // Next state, request capture and RAM/response decode for the coming edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        cur_idx_s  = idx_q;
        cur_we_s   = we_q;
        cur_sel_s  = sel_q;
        cur_wdat_s = wdat_q;
        go_resp_s  = 1'b0;
`ifdef WB_DATA_RAM_ERR_EN
        oor_d      = oor_q;
        cur_oor_s  = oor_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cyc_i && bus.stb_i) begin
                    idx_d  = bus.adr_i[AW+1:2];
                    we_d   = bus.we_i;
                    sel_d  = bus.sel_i;
                    wdat_d = bus.dat_i;
                    cnt_d  = WAIT_INIT;
`ifdef WB_DATA_RAM_ERR_EN
                    oor_d     = addr_out_of_range(bus.adr_i, AW);
                    cur_oor_s = oor_d;
`endif
                    // Zero wait states commit straight from the live bus inputs.
                    cur_idx_s  = idx_d;
                    cur_we_s   = we_d;
                    cur_sel_s  = sel_d;
                    cur_wdat_s = wdat_d;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        go_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!bus.cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WB_CNTW'(1)) begin
                    state_d   = RESP;
                    cnt_d     = cnt_q - WB_CNTW'(1);
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - WB_CNTW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef WB_DATA_RAM_ERR_EN
        blocked_s = cur_oor_s;
        err_d     = go_resp_s && blocked_s;
`else
        blocked_s = 1'b0;
        err_d     = 1'b0;
`endif
        ack_d    = go_resp_s && !blocked_s;
        ram_re_s = go_resp_s && !cur_we_s && !blocked_s;
        // Held reset must never let a pending bus write reach the array.
        if (go_resp_s && cur_we_s && !blocked_s && rst) begin
            ram_we_s = cur_sel_s;
        end else begin
            ram_we_s = '0;
        end
    end

    // FSM, counter, captured request and response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_DATA_RAM_ERR_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef WB_DATA_RAM_ERR_EN
            oor_q   <= oor_d;
`endif
        end
    end

    ram_sp_bytewe #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (cur_idx_s),
        .wdata (cur_wdat_s),
        .rdata (ram_rdata_s)
    );

    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.dat_o = ram_rdata_s;

endmodule

// File: tb/tb_wb_data_ram.sv
// Scoreboard bench for wb_data_ram: one instance with no wait states, one with
// three; expectations are queued at request time and matched on each response.
module tb_wb_data_ram;
    import wb_pkg::*;

    localparam int DEPTH = 1024;
`ifdef WB_DATA_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc_cnt = 32'd0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a;
    exp_t        e_b;
    logic [31:0] mdl [int];

    wb_data_ram_if bus_a ();
    wb_data_ram_if bus_b ();

    wb_data_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    wb_data_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int unit, input logic cyc, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        if (unit == 0) begin
            bus_a.cyc_i = cyc; bus_a.stb_i = cyc; bus_a.we_i = we;
            bus_a.adr_i = adr; bus_a.sel_i = sel; bus_a.dat_i = dat;
        end else begin
            bus_b.cyc_i = cyc; bus_b.stb_i = cyc; bus_b.we_i = we;
            bus_b.adr_i = adr; bus_b.sel_i = sel; bus_b.dat_i = dat;
        end
    endtask

    task automatic idle_bus(input int unit);
        drive(unit, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Queue the response a request sampled at the next edge must produce.
    task automatic expect_xfer(input int unit, input logic we, input logic [31:0] adr,
                               input logic [3:0] sel, input logic [31:0] dat, input int lat);
        exp_t        e;
        int          key;
        logic [31:0] word;
        key   = unit * DEPTH + int'(adr[11:2]);
        e.err = ERR_EN && (adr >= 32'(4 * DEPTH));
        e.dat = 32'h0;
        e.cyc = cyc_cnt + 32'(lat);
        if (!e.err) begin
            word = mdl.exists(key) ? mdl[key] : 32'h0;
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel[k]) word[8*k +: 8] = dat[8*k +: 8];
                end
                mdl[key] = word;
            end else begin
                e.dat = word;
            end
        end
        if (unit == 0) q_a.push_back(e);
        else           q_b.push_back(e);
    endtask

    // One complete transfer; entered and left on a falling edge.
    task automatic xfer(input int unit, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        int lat;
        lat = (unit == 0) ? 1 : 4;
        expect_xfer(unit, we, adr, sel, dat, lat);
        drive(unit, 1'b1, we, adr, sel, dat);
        repeat (lat) @(negedge clk);
        idle_bus(unit);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus_a.ack_o || bus_a.err_o) begin
            if (q_a.size() == 0) begin
                check_eq("a_unexpected_resp", {31'd0, 1'b1}, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check_eq("a_ack", {31'd0, bus_a.ack_o}, {31'd0, ~e_a.err});
                check_eq("a_err", {31'd0, bus_a.err_o}, {31'd0, e_a.err});
                check_eq("a_dat", bus_a.dat_o, e_a.dat);
                check_eq("a_cycle", cyc_cnt, e_a.cyc);
            end
        end else begin
            check_eq("a_dat_idle", bus_a.dat_o, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (bus_b.ack_o || bus_b.err_o) begin
            if (q_b.size() == 0) begin
                check_eq("b_unexpected_resp", {31'd0, 1'b1}, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check_eq("b_ack", {31'd0, bus_b.ack_o}, {31'd0, ~e_b.err});
                check_eq("b_err", {31'd0, bus_b.err_o}, {31'd0, e_b.err});
                check_eq("b_dat", bus_b.dat_o, e_b.dat);
                check_eq("b_cycle", cyc_cnt, e_b.cyc);
            end
        end else begin
            check_eq("b_dat_idle", bus_b.dat_o, 32'd0);
        end
    end

    initial begin
        logic        we_v;
        logic [31:0] adr_v;
        logic [3:0]  sel_v;
        logic [31:0] dat_v;

        // Request held through reset; it must be served only after release.
        drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h55AA_00FF);
        drive(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h55AA_00FF);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        expect_xfer(0, 1'b1, 32'h40, 4'hF, 32'h55AA_00FF, 1);
        expect_xfer(1, 1'b1, 32'h40, 4'hF, 32'h55AA_00FF, 4);
        @(negedge clk);
        idle_bus(0);
        repeat (3) @(negedge clk);
        idle_bus(1);
        @(negedge clk);

        xfer(0, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
        xfer(0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
        xfer(0, 1'b1, 32'h20, 4'b0010, 32'h0000_AB00);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0);
        xfer(0, 1'b1, 32'h30, 4'hF, 32'h0);
        xfer(0, 1'b1, 32'h31, 4'b1000, 32'hA500_0000);
        xfer(0, 1'b0, 32'h33, 4'h0, 32'h0);
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h0);
        xfer(0, 1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'h0);
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0);

        // Strobe held six cycles: responses only on cycles 1, 3 and 5.
        expect_xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 1);
        expect_xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 3);
        expect_xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 5);
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        repeat (6) @(negedge clk);
        idle_bus(0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom);
        end
        for (int i = 0; i < 24; i++) begin
            we_v  = 1'($urandom_range(0, 1));
            adr_v = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            sel_v = 4'($urandom_range(1, 15));
            dat_v = $urandom;
            xfer(0, we_v, adr_v, sel_v, dat_v);
        end

        xfer(1, 1'b1, 32'h8, 4'hF, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h8, 4'h0, 32'h0);
        // Write aborted by dropping cyc_i two edges into the wait states.
        drive(1, 1'b1, 1'b1, 32'h8, 4'hF, 32'h1111_2222);
        repeat (2) @(negedge clk);
        idle_bus(1);
        repeat (6) @(negedge clk);
        xfer(1, 1'b0, 32'h8, 4'hF, 32'h0);
        xfer(1, 1'b1, 32'h4, 4'hF, 32'h0102_0304);
        xfer(1, 1'b1, 32'h1004, 4'hF, 32'h7777_7777);
        xfer(1, 1'b0, 32'h4, 4'hF, 32'h0);

        repeat (8) @(negedge clk);
        check_eq("a_pending", 32'(q_a.size()), 32'd0);
        check_eq("b_pending", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
